// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared encodings for the hazard/forwarding controller.
//   ResultSrc encodings (RS_*), EX operand-forward encodings (FWD_*),
//   multi-cycle lock-out FSM states (mc_state_e).
package hazard_pkg;

  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;
  localparam logic [1:0] RS_IMM  = 2'b11;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_M_ALU = 2'b10;
  localparam logic [1:0] FWD_W     = 2'b01;
  localparam logic [1:0] FWD_M_IMM = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master: datapath side (drives pipeline status, receives stall/flush/forward)
//   slave : hazard controller side
// Parameters: REG_AW register address width, CNT_W perf counter width.
interface hazard_ctrl_mc_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);

  logic              RegWriteM;
  logic              RegWriteW;
  logic [1:0]        ResultSrcE;
  logic [1:0]        ResultSrcM;
  logic [1:0]        ResultSrcW;
  logic              PCSrcE;
  logic              McStartE;
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] RdM;
  logic [REG_AW-1:0] RdW;

  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              McBusy;
  logic [CNT_W-1:0]  StallCnt;
  logic [CNT_W-1:0]  FlushCnt;

  modport master (
    output RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
           PCSrcE, McStartE, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, McBusy, StallCnt, FlushCnt
  );

  modport slave (
    input  RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
           PCSrcE, McStartE, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, McBusy, StallCnt, FlushCnt
  );

endinterface

// File: rtl/hazard_ctrl_mc_fwd_sel.sv
// Combinational EX operand-forward select for one source operand.
//   rs            EX source register
//   rd_m, rd_w    MEM / WB destination registers
//   reg_write_m/w MEM / WB write enables
//   result_src_m/w MEM / WB result source
//   fwd           forward select (FWD_*)
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic [1:0]        result_src_m,
  input  logic [1:0]        result_src_w,
  output logic [1:0]        fwd
);

  logic rs_nz;
  logic hit_m;
  logic hit_w;

  assign rs_nz = (rs != '0);
  assign hit_m = rs_nz && (rs == rd_m);
  assign hit_w = rs_nz && (rs == rd_w);

  // MEM beats WB; LUI in MEM forwards its immediate even without RegWriteM.
  always_comb begin
    fwd = FWD_RF;
    if (hit_m && reg_write_m && (result_src_m != RS_IMM)) begin
      fwd = FWD_M_ALU;
    end else if (hit_m && (result_src_m == RS_IMM)) begin
      fwd = FWD_M_IMM;
    end else if (hit_w && (reg_write_w || (result_src_w == RS_IMM))) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline with a multi-cycle
// EX unit lock-out, load-use detection and branch-over-stall priority.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   hz   hazard_ctrl_mc_if.slave bundle (pipeline status in, stall/flush/
//        forward selects, McBusy and perf counters out)
// Parameters: REG_AW, MC_LATENCY (cycles a multi-cycle op holds EX), CNT_W.
// Build option: define HAZ_PERF_CNT_EN to enable the StallCnt/FlushCnt
// saturating performance counters; otherwise they read 0.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_mc_if.slave  hz
);

  localparam int unsigned MC_CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
  localparam int unsigned MC_LOAD  = (MC_LATENCY > 1) ? (MC_LATENCY - 2) : 0;
  localparam logic        MC_EN    = (MC_LATENCY > 1);

  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] BUSY = ST_BUSY;

  logic [0:0]          state;
  logic [0:0]          state_nxt;
  logic [MC_CNT_W-1:0] mc_cnt;
  logic [MC_CNT_W-1:0] mc_cnt_nxt;
  logic                mc_busy;
  logic                lw_stall;

  // Operand forward selects.
  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs           (hz.Rs1E),
    .rd_m         (hz.RdM),
    .rd_w         (hz.RdW),
    .reg_write_m  (hz.RegWriteM),
    .reg_write_w  (hz.RegWriteW),
    .result_src_m (hz.ResultSrcM),
    .result_src_w (hz.ResultSrcW),
    .fwd          (hz.ForwardAE)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs           (hz.Rs2E),
    .rd_m         (hz.RdM),
    .rd_w         (hz.RdW),
    .reg_write_m  (hz.RegWriteM),
    .reg_write_w  (hz.RegWriteW),
    .result_src_m (hz.ResultSrcM),
    .result_src_w (hz.ResultSrcW),
    .fwd          (hz.ForwardBE)
  );

  // Lock-out FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
    end
  end

  // Next state: the starting cycle is the first EX cycle, so BUSY covers
  // the remaining MC_LATENCY-1 cycles (counter loads MC_LATENCY-2).
  always_comb begin
    state_nxt  = state;
    mc_cnt_nxt = mc_cnt;
    case (state)
      IDLE: begin
        if (hz.McStartE && MC_EN) begin
          state_nxt  = BUSY;
          mc_cnt_nxt = MC_CNT_W'(MC_LOAD);
        end
      end
      BUSY: begin
        if (mc_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          mc_cnt_nxt = mc_cnt - MC_CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mc_busy  = (state == BUSY) || ((state == IDLE) && hz.McStartE && MC_EN);
  assign lw_stall = (hz.ResultSrcE == RS_LOAD) && (hz.RdE != '0) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

  // Stall/flush priority: multi-cycle lock-out > taken branch > load-use.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushM = 1'b0;
    if (mc_busy) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.FlushM = 1'b1;
    end else if (hz.PCSrcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (lw_stall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

  assign hz.McBusy = mc_busy;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.StallF && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if ((hz.FlushD || hz.FlushE || hz.FlushM) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign hz.StallCnt = stall_cnt;
  assign hz.FlushCnt = flush_cnt;
`else
  assign hz.StallCnt = CNT_W'(0);
  assign hz.FlushCnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_hazard_ctrl_mc;
  import hazard_pkg::*;

  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 4;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_mc_if #(.REG_AW(AW), .CNT_W(CW)) hz ();

  hazard_ctrl_mc #(.REG_AW(AW), .MC_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: cycles of lock-out still owed after this one.
  int busy_left = 0;
  int stall_cnt = 0;
  int flush_cnt = 0;
  int busy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input int rs, input int rdm, input int rdw,
                                         input logic rwm, input logic rww,
                                         input logic [1:0] rsm, input logic [1:0] rsw);
    if (rs == 0) return 2'b00;
    if (rs == rdm && rsm == 2'b11) return 2'b11;
    if (rs == rdm && rwm) return 2'b10;
    if (rs == rdw && (rww || rsw == 2'b11)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.ResultSrcE = 0; hz.ResultSrcM = 0; hz.ResultSrcW = 0;
    hz.PCSrcE = 0; hz.McStartE = 0;
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
    hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model.
  task automatic step(input string tag);
    logic busy, lw, sf, sd, se, fd, fe, fm;
    @(negedge clk);
    busy = (busy_left > 0) || (hz.McStartE && LAT > 1);
    lw = (hz.ResultSrcE == 2'b01) && (hz.RdE != 0) &&
         (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
    {sf, sd, se, fd, fe, fm} = '0;
    if (busy) {sf, sd, se, fm} = 4'b1111;
    else if (hz.PCSrcE) {fd, fe} = 2'b11;
    else if (lw) {sf, sd, fe} = 3'b111;
    chk({tag, ".McBusy"}, 32'(hz.McBusy), 32'(busy));
    chk({tag, ".StallF"}, 32'(hz.StallF), 32'(sf));
    chk({tag, ".StallD"}, 32'(hz.StallD), 32'(sd));
    chk({tag, ".StallE"}, 32'(hz.StallE), 32'(se));
    chk({tag, ".FlushD"}, 32'(hz.FlushD), 32'(fd));
    chk({tag, ".FlushE"}, 32'(hz.FlushE), 32'(fe));
    chk({tag, ".FlushM"}, 32'(hz.FlushM), 32'(fm));
    chk({tag, ".FwdA"}, 32'(hz.ForwardAE),
        32'(ref_fwd(int'(hz.Rs1E), int'(hz.RdM), int'(hz.RdW), hz.RegWriteM,
                    hz.RegWriteW, hz.ResultSrcM, hz.ResultSrcW)));
    chk({tag, ".FwdB"}, 32'(hz.ForwardBE),
        32'(ref_fwd(int'(hz.Rs2E), int'(hz.RdM), int'(hz.RdW), hz.RegWriteM,
                    hz.RegWriteW, hz.ResultSrcM, hz.ResultSrcW)));
    chk({tag, ".StallCnt"}, 32'(hz.StallCnt), 32'(stall_cnt));
    chk({tag, ".FlushCnt"}, 32'(hz.FlushCnt), 32'(flush_cnt));
    @(posedge clk);
    if (rst) begin
      busy_left = 0;
      stall_cnt = 0;
      flush_cnt = 0;
    end else begin
      if (busy_left > 0) busy_left--;
      else if (hz.McStartE && LAT > 1) busy_left = LAT - 1;
      if (PERF) begin
        if (sf && stall_cnt < CNT_MAX) stall_cnt++;
        if ((fd || fe || fm) && flush_cnt < CNT_MAX) flush_cnt++;
      end
    end
    #1;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    clear_inputs();
    #1;
    step("rst0");
    step("rst1");
    rst = 1'b0;
    step("idle");
    chk("reset.McBusy", 32'(hz.McBusy), 32'd0);

    // 1: MEM ALU result beats WB; x0 never forwards
    hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1;
    #1; chk("t1.fwdA_mem", 32'(hz.ForwardAE), 32'(FWD_M_ALU));
    step("t1a");
    hz.Rs1E = 0; hz.RdM = 0; hz.RdW = 0;
    #1; chk("t1.fwdA_x0", 32'(hz.ForwardAE), 32'(FWD_RF));
    step("t1b");
    clear_inputs();

    // 2: LUI immediate from MEM; LUI in WB without RegWriteW
    hz.Rs2E = 7; hz.RdM = 7; hz.ResultSrcM = 2'b11; hz.RegWriteM = 1;
    #1; chk("t2.fwdB_imm", 32'(hz.ForwardBE), 32'(FWD_M_IMM));
    step("t2a");
    hz.RdM = 3; hz.RdW = 7; hz.ResultSrcW = 2'b11; hz.RegWriteW = 0;
    #1; chk("t2.fwdB_wb", 32'(hz.ForwardBE), 32'(FWD_W));
    step("t2b");
    clear_inputs();

    // 3: load-use, and no stall for a load to x0
    hz.ResultSrcE = 2'b01; hz.RdE = 4; hz.Rs2D = 4;
    #1; chk("t3.lw_stallF", 32'(hz.StallF), 32'd1);
    step("t3a");
    hz.RdE = 0; hz.Rs2D = 0;
    step("t3b");

    // 4: taken branch overrides load-use
    hz.RdE = 4; hz.Rs1D = 4; hz.PCSrcE = 1;
    #1; chk("t4.stallD", 32'(hz.StallD), 32'd0);
    step("t4");
    clear_inputs();

    // 5: multi-cycle op locks EX for exactly LAT cycles, branch ignored
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      hz.McStartE = (i == 0);
      hz.PCSrcE   = (i == 2);
      #1; if (hz.McBusy) busy_seen++;
      step("t5");
    end
    chk("t5.busy_len", 32'(busy_seen), 32'(LAT));
    clear_inputs();

    // 6: reset in second busy cycle clears lock-out
    hz.McStartE = 1;
    step("t6a");
    hz.McStartE = 0; rst = 1'b1;
    step("t6b");
    rst = 1'b0;
    #1; chk("t6.busy_after_rst", 32'(hz.McBusy), 32'd0);
    step("t6c");
    step("t6d");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      hz.RegWriteM  = 1'($urandom);
      hz.RegWriteW  = 1'($urandom);
      hz.ResultSrcE = 2'($urandom);
      hz.ResultSrcM = 2'($urandom);
      hz.ResultSrcW = 2'($urandom);
      hz.PCSrcE     = ($urandom_range(0, 3) == 0);
      hz.McStartE   = ($urandom_range(0, 7) == 0);
      hz.Rs1D = AW'($urandom_range(0, 7));
      hz.Rs2D = AW'($urandom_range(0, 7));
      hz.Rs1E = AW'($urandom_range(0, 7));
      hz.Rs2E = AW'($urandom_range(0, 7));
      hz.RdE  = AW'($urandom_range(0, 7));
      hz.RdM  = AW'($urandom_range(0, 7));
      hz.RdW  = AW'($urandom_range(0, 7));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
